// File: rtl/spi_slave_driver_if.sv
// System-side and SPI pin signals of the SPI slave, bundled for port connection.
interface spi_slave_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data_bi;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_bo;
  logic                  rx_valid_o;
  logic                  tx_underrun_o;
  logic                  frame_abort_o;
  logic                  busy_o;
  logic                  spi_sclk_i;
  logic                  spi_cs_i;
  logic                  spi_mosi_i;
  logic                  spi_miso_o;

  // DUT side
  modport slave (
    input  tx_data_bi, tx_valid_i, spi_sclk_i, spi_cs_i, spi_mosi_i,
    output tx_ready_o, rx_data_bo, rx_valid_o, tx_underrun_o, frame_abort_o,
           busy_o, spi_miso_o
  );

  // SPI master plus system front-end side
  modport master (
    output tx_data_bi, tx_valid_i, spi_sclk_i, spi_cs_i, spi_mosi_i,
    input  tx_ready_o, rx_data_bo, rx_valid_o, tx_underrun_o, frame_abort_o,
           busy_o, spi_miso_o
  );
endinterface

// File: rtl/spi_slave_driver.sv
// SPI slave, CPOL=0 / CPHA=0, LSB first. Pins are oversampled in the clk_i
// domain; a one-entry TX buffer feeds MISO, received bytes leave as a pulse.
module spi_slave_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_slave_driver_if.slave   bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                 state, state_next;
  logic                   load, sample, shift_out, drop, abort;

  logic                   buf_full;
  logic [DATA_WIDTH-1:0]  buf_data;
  logic                   wr;
  logic [DATA_WIDTH-1:0]  load_val;

  logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_next;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_asm;
  logic [CW-1:0]          count;
  logic                   last_bit;

  logic [DATA_WIDTH-1:0]  rx_data;
  logic                   rx_valid, underrun, frame_abort, miso;

  // Pin synchronizers (idle levels on reset) plus one delay flop per line
  // so edges are taken between two already-settled samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign cs_fall   = ~cs_s   &  cs_d;
  assign cs_rise   =  cs_s   & ~cs_d;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: a frame is bounded by the synced CS edges.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: CS rise outranks any SCLK edge seen in the same cycle.
  always_comb begin
    load      = 1'b0;
    sample    = 1'b0;
    shift_out = 1'b0;
    drop      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: load = cs_fall;
      SHIFT: begin
        if (cs_rise) begin
          drop  = 1'b1;
          abort = (count != '0);
        end else begin
          sample = sclk_rise;
          if (sclk_fall) begin
            if (count == '0) load      = 1'b1;
            else             shift_out = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // A load decision looks at the buffer before any same-cycle write lands.
  assign wr            = bus.tx_valid_i & ~buf_full;
  assign load_val      = buf_full ? buf_data : '0;
  assign tx_shift_next = tx_shift >> 1;
  assign last_bit      = (count == CW'(DATA_WIDTH - 1));

  always_comb begin
    rx_asm        = rx_shift;
    rx_asm[count] = mosi_s;
  end

  // One-entry TX buffer: a write fills it, a load empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (wr) begin
      buf_full <= 1'b1;
      buf_data <= bus.tx_data_bi;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Shift datapath: MISO drive, MOSI assembly, bit count and event pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      count       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
      miso        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= abort;
      if (drop) begin
        miso  <= 1'b0;
        count <= '0;
      end else begin
        if (load) begin
          tx_shift <= load_val;
          miso     <= load_val[0];
          underrun <= ~buf_full;
        end else if (shift_out) begin
          tx_shift <= tx_shift_next;
          miso     <= tx_shift_next[0];
        end
        if (sample) begin
          rx_shift <= rx_asm;
          if (last_bit) begin
            rx_data  <= rx_asm;
            rx_valid <= 1'b1;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
      end
    end
  end

  assign bus.tx_ready_o    = ~buf_full;
  assign bus.rx_data_bo    = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.tx_underrun_o = underrun;
  assign bus.frame_abort_o = frame_abort;
  assign bus.busy_o        = ~cs_s;
  assign bus.spi_miso_o    = miso;
endmodule

// File: tb/tb_spi_slave_driver.sv
// Bench for spi_slave_driver: a bench-side SPI master with a byte-level model
// of the TX buffer, plus a scoreboard process watching the pulse outputs.
module tb_spi_slave_driver;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_driver_if #(.DATA_WIDTH(8)) bus ();
  spi_slave_driver #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: TX buffer occupancy and expected event streams.
  logic       m_full = 1'b0;
  logic [7:0] m_data = '0;
  logic [7:0] exp_rx[$];
  int exp_under = 0, exp_abort = 0;
  int n_rxv = 0, n_under = 0, n_abort = 0;

  logic [7:0] f_mosi[4];
  int         f_wr[4];
  logic [7:0] f_miso[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_load();
    logic [7:0] v;
    if (m_full) begin
      v = m_data;
      m_full = 1'b0;
    end else begin
      v = 8'h00;
      exp_under++;
    end
    return v;
  endfunction

  task automatic do_write(input logic [7:0] d);
    @(negedge clk);
    chk("tx_ready_before_write", bus.tx_ready_o, !m_full);
    bus.tx_data_bi = d;
    bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_data = d;
    end
    chk("tx_ready_after_write", bus.tx_ready_o, 0);
  endtask

  // mode 0: normal end, 1: CS abort after k rises of last byte, 2: reset after k rises
  task automatic run_frame(input int nb, input int mode, input int k);
    logic [7:0] got, expm, mask;
    for (int b = 0; b < 4; b++) f_miso[b] = '0;
    @(negedge clk);
    bus.spi_cs_i = 1'b0;
    expm = model_load();
    for (int b = 0; b < nb; b++) begin
      got = '0;
      for (int i = 0; i < 8; i++) begin
        bus.spi_mosi_i = f_mosi[b][i];
        wait_cyc(HALF);
        bus.spi_sclk_i = 1'b1;
        got[i] = bus.spi_miso_o;
        if (b == 0 && i == 0) begin
          chk("busy_in_frame", bus.busy_o, 1);
          chk("tx_ready_after_load", bus.tx_ready_o, !m_full);
        end
        if (i == 7) exp_rx.push_back(f_mosi[b]);
        wait_cyc(HALF);
        if (i == 3 && f_wr[b] >= 0) do_write(8'(f_wr[b]));
        if (b == nb - 1 && mode != 0 && i == k - 1) begin
          mask = 8'((1 << k) - 1);
          chk("miso_partial", got & mask, expm & mask);
          f_miso[b] = got;
          if (mode == 1) begin
            bus.spi_sclk_i = 1'b0;
            wait_cyc(HALF);
            bus.spi_cs_i = 1'b1;
            exp_abort++;
            wait_cyc(HALF + 4);
            chk("busy_after_abort", bus.busy_o, 0);
          end else begin
            rst = 1'b1;
            bus.spi_cs_i   = 1'b1;
            bus.spi_sclk_i = 1'b0;
            bus.spi_mosi_i = 1'b0;
            #1;
            chk("reset_flags", {bus.tx_ready_o, bus.busy_o, bus.spi_miso_o, bus.rx_valid_o,
                                bus.tx_underrun_o, bus.frame_abort_o}, 6'b100000);
            chk("reset_rx_data", bus.rx_data_bo, 0);
            m_full = 1'b0;
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(4);
          end
          return;
        end
        if (i == 7) begin
          chk("miso_byte", got, expm);
          f_miso[b] = got;
          bus.spi_sclk_i = 1'b0;
          if (b == nb - 1) bus.spi_cs_i = 1'b1;
          else             expm = model_load();
        end else begin
          bus.spi_sclk_i = 1'b0;
        end
      end
    end
    wait_cyc(HALF + 4);
    chk("busy_idle", bus.busy_o, 0);
    chk("miso_idle", bus.spi_miso_o, 0);
  endtask

  task automatic clear_frame();
    for (int b = 0; b < 4; b++) begin
      f_mosi[b] = '0;
      f_wr[b]   = -1;
    end
  endtask

  // Scoreboard: every pulse must be expected and last exactly one cycle.
  logic p_rxv = 1'b0, p_un = 1'b0, p_ab = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid_o) begin
        n_rxv++;
        if (exp_rx.size() == 0) chk("rx_unexpected", bus.rx_valid_o, 0);
        else                    chk("rx_data", bus.rx_data_bo, exp_rx.pop_front());
      end
      if (bus.tx_underrun_o) begin
        n_under++;
        if (exp_under == 0) chk("underrun_unexpected", bus.tx_underrun_o, 0);
        else begin
          exp_under--;
          checks++;
        end
      end
      if (bus.frame_abort_o) begin
        n_abort++;
        if (exp_abort == 0) chk("abort_unexpected", bus.frame_abort_o, 0);
        else begin
          exp_abort--;
          checks++;
        end
      end
      if (bus.rx_valid_o || bus.tx_underrun_o || bus.frame_abort_o)
        chk("pulse_width", {bus.rx_valid_o & p_rxv, bus.tx_underrun_o & p_un,
                            bus.frame_abort_o & p_ab}, 0);
    end
    p_rxv = bus.rx_valid_o;
    p_un  = bus.tx_underrun_o;
    p_ab  = bus.frame_abort_o;
  end

  initial begin
    int r0, u0, a0, nb, mode, k;
    bus.tx_data_bi = '0;
    bus.tx_valid_i = 1'b0;
    bus.spi_sclk_i = 1'b0;
    bus.spi_cs_i   = 1'b1;
    bus.spi_mosi_i = 1'b0;
    clear_frame();
    wait_cyc(3);
    chk("reset_flags", {bus.tx_ready_o, bus.busy_o, bus.spi_miso_o, bus.rx_valid_o,
                        bus.tx_underrun_o, bus.frame_abort_o}, 6'b100000);
    chk("reset_rx_data", bus.rx_data_bo, 0);
    rst = 1'b0;
    wait_cyc(4);

    // 1: preloaded A5, master sends 3C
    clear_frame();
    do_write(8'hA5);
    f_mosi[0] = 8'h3C;
    r0 = n_rxv;
    run_frame(1, 0, 0);
    chk("t1_miso", f_miso[0], 8'hA5);
    chk("t1_rx", bus.rx_data_bo, 8'h3C);
    chk("t1_rx_count", n_rxv - r0, 1);

    // 2: no write, master sends 5A
    clear_frame();
    f_mosi[0] = 8'h5A;
    u0 = n_under;
    run_frame(1, 0, 0);
    chk("t2_miso", f_miso[0], 8'h00);
    chk("t2_underruns", n_under - u0, 1);
    chk("t2_rx", bus.rx_data_bo, 8'h5A);

    // 3: abort after 3 rises, then a full 81 frame
    clear_frame();
    f_mosi[0] = 8'hE7;
    r0 = n_rxv;
    a0 = n_abort;
    run_frame(1, 1, 3);
    wait_cyc(4);
    chk("t3_aborts", n_abort - a0, 1);
    chk("t3_no_rx", n_rxv - r0, 0);
    f_mosi[0] = 8'h81;
    run_frame(1, 0, 0);
    chk("t3_rx", bus.rx_data_bo, 8'h81);

    // 4: two-byte frame, 11 preloaded, 22 written mid-frame
    clear_frame();
    do_write(8'h11);
    f_mosi[0] = 8'hF0;
    f_mosi[1] = 8'h0F;
    f_wr[0]   = 8'h22;
    r0 = n_rxv;
    run_frame(2, 0, 0);
    chk("t4_miso0", f_miso[0], 8'h11);
    chk("t4_miso1", f_miso[1], 8'h22);
    chk("t4_rx_count", n_rxv - r0, 2);
    chk("t4_rx", bus.rx_data_bo, 8'h0F);

    // 5: reset after 4 bits, then 77
    clear_frame();
    f_mosi[0] = 8'hFF;
    run_frame(1, 2, 4);
    f_mosi[0] = 8'h77;
    run_frame(1, 0, 0);
    chk("t5_rx", bus.rx_data_bo, 8'h77);

    // 6: second write while full is dropped
    clear_frame();
    do_write(8'h12);
    do_write(8'h34);
    f_mosi[0] = 8'h99;
    run_frame(1, 0, 0);
    chk("t6_miso", f_miso[0], 8'h12);

    // Random frames
    for (int t = 0; t < 40; t++) begin
      clear_frame();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        f_mosi[b] = 8'($urandom);
        f_wr[b]   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1;
      end
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
      if ($urandom_range(0, 3) == 0) do_write(8'($urandom));
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      k    = int'($urandom_range(1, 7));
      run_frame(nb, mode, k);
      wait_cyc(int'($urandom_range(2, 10)));
    end

    wait_cyc(10);
    chk("rx_all_seen", exp_rx.size(), 0);
    chk("underruns_all_seen", exp_under, 0);
    chk("aborts_all_seen", exp_abort, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
